// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, serial 1-bit/cycle shifter,
// valid/ready on both sides, registered result and zero flag.
module ex_alu_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [3:0]      i_alu_ctr,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_busy
);

    // Operation codes shared with ALU-control decode ({funct7[5], funct3}).
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // state | meaning
    // IDLE  | waiting for an operation
    // SHIFT | serial shifter running, one bit per cycle
    // DONE  | result/zero valid, held until downstream accepts
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_work;
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_shift;
    logic [SHW-1:0]    w_cnt_in;
    logic              w_go_shift;
    logic              w_lt_s;
    logic              w_lt_u;
    logic [XLEN-1:0]   w_single_res;
    logic [XLEN-1:0]   w_shift_next;
    logic              w_shift_last;

    assign w_in_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & i_out_ready);
    // An op offered during flush sees in_ready but is dropped.
    assign w_accept     = i_in_valid & w_in_ready & ~i_flush;
    assign w_is_shift   = (i_alu_ctr == ALU_SLL) | (i_alu_ctr == ALU_SRL) | (i_alu_ctr == ALU_SRA);
    assign w_cnt_in     = i_op_b[SHW-1:0];
    assign w_go_shift   = w_is_shift & (w_cnt_in != '0);
    assign w_lt_s       = $signed(i_op_a) < $signed(i_op_b);
    assign w_lt_u       = i_op_a < i_op_b;
    assign w_shift_last = (r_cnt == SHW'(1));

    always_comb begin
        w_single_res = i_op_a + i_op_b;
        case (i_alu_ctr)
            ALU_ADD:  w_single_res = i_op_a + i_op_b;
            ALU_SUB:  w_single_res = i_op_a - i_op_b;
            ALU_SLT:  w_single_res = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: w_single_res = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:  w_single_res = i_op_a ^ i_op_b;
            ALU_OR:   w_single_res = i_op_a | i_op_b;
            ALU_AND:  w_single_res = i_op_a & i_op_b;
            // Only reached with a zero shift amount.
            ALU_SLL, ALU_SRL, ALU_SRA: w_single_res = i_op_a;
            default:  w_single_res = i_op_a + i_op_b;
        endcase
    end

    always_comb begin
        w_shift_next = r_work;
        case (r_op)
            ALU_SLL: w_shift_next = {r_work[XLEN-2:0], 1'b0};
            ALU_SRL: w_shift_next = {1'b0, r_work[XLEN-1:1]};
            ALU_SRA: w_shift_next = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_shift_next = r_work;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            w_state_next = w_go_shift ? ST_SHIFT : ST_DONE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_IDLE;
                ST_SHIFT: w_state_next = w_shift_last ? ST_DONE : ST_SHIFT;
                ST_DONE:  w_state_next = i_out_ready ? ST_IDLE : ST_DONE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= i_alu_ctr;
            r_cnt <= w_cnt_in;
            if (w_go_shift) begin
                r_work <= i_op_a;
            end else begin
                r_result <= w_single_res;
                r_zero   <= (w_single_res == '0);
            end
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_shift_next;
            r_cnt  <= r_cnt - SHW'(1);
            if (w_shift_last) begin
                r_result <= w_shift_next;
                r_zero   <= (w_shift_next == '0);
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_SHIFT);
    assign o_result    = r_result;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: single-cycle ops, serial shifts, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_ex_alu_unit;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_alu_unit #(.XLEN(32), .SHW(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_alu_ctr   (alu_ctr),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_zero      (zero),
        .o_busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_ctr  = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
    endtask

    // Offer an op, expect it taken on the next edge and its result visible right after.
    task automatic single_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input logic expz);
        drive(op, a, b);
        #1;
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick;
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_result"}, result, exp);
        check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, expz});
    endtask

    task automatic do_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int k);
        int lat;
        int nbusy;
        int nready;
        drive(op, a, b);
        tick;
        in_valid = 1'b0;
        lat    = 0;
        nbusy  = 0;
        nready = 0;
        while (!out_valid && lat < 80) begin
            if (busy) nbusy++;
            if (in_ready) nready++;
            tick;
            lat++;
        end
        check_val({tag, "_latency"}, lat, k);
        check_val({tag, "_busy_cycles"}, nbusy, k);
        check_val({tag, "_ready_in_shift"}, nready, 0);
        check_val({tag, "_result"}, result, exp);
        tick;
    endtask

    initial begin
        int stable;
        int seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctr   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_zero", {31'd0, zero}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        tick;

        // Back-to-back single-cycle ops, in_valid held high throughout.
        single_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        single_op("sub", ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1);
        single_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        single_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        single_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        single_op("unknown_add", 4'b1111, 32'd2, 32'd3, 32'd5, 1'b0);
        in_valid = 1'b0;
        tick;
        check_val("idle_after_b2b", {31'd0, out_valid}, 32'd0);

        do_shift("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
        do_shift("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4);
        do_shift("sll31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 31);
        do_shift("sll0", ALU_SLL, 32'h12, 32'd0, 32'h12, 0);
        do_shift("sll_b25", ALU_SLL, 32'd3, 32'h25, 32'h60, 5);

        // Backpressure with a second op waiting.
        out_ready = 1'b0;
        drive(ALU_XOR, 32'hF0, 32'hFF);
        tick;
        drive(ALU_OR, 32'h30, 32'h03);
        stable = 1;
        repeat (5) begin
            if (result !== 32'h0F || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
            tick;
        end
        check_val("bp_hold", stable, 1);
        out_ready = 1'b1;
        #1;
        check_val("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
        tick;
        check_val("bp_or_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_or_result", result, 32'h33);
        in_valid = 1'b0;
        tick;
        check_val("bp_idle", {31'd0, out_valid}, 32'd0);

        // Flush in the third cycle of a 10-bit shift.
        drive(ALU_SLL, 32'd1, 32'd10);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        flush = 1'b1;
        tick;
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        check_val("flush_valid", {31'd0, out_valid}, 32'd0);
        drive(ALU_ADD, 32'd1, 32'd1);
        tick;
        check_val("flush_drop_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush_keep_result", result, 32'h33);
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (12) begin
            if (out_valid || busy) seen++;
            tick;
        end
        check_val("flush_quiet", seen, 0);
        single_op("and", ALU_AND, 32'hC, 32'hA, 32'h8, 1'b0);
        in_valid = 1'b0;
        tick;

        // Asynchronous reset in the middle of a shift.
        drive(ALU_SLL, 32'd1, 32'd20);
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        check_val("ar_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_busy", {31'd0, busy}, 32'd0);
        check_val("ar_valid", {31'd0, out_valid}, 32'd0);
        check_val("ar_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            tick;
            if (out_valid) seen++;
        end
        check_val("ar_no_result", seen, 0);
        check_val("ar_in_ready", {31'd0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
# ex_alu_unit

Execute-stage ALU that consumes the 4-bit `alu_ctr` operation code produced by ALU-control decode, together with two operands, and returns a registered result. It uses a valid/ready handshake on both sides. Logical, arithmetic and compare operations complete in one cycle. Shifts use a serial one-bit-per-cycle shifter to save area. It sits between the ID/EX operand path and the EX/MEM result register, and its `zero` flag feeds the branch decision.

## Interface
- `XLEN`, default 32: operand and result width.
- `SHW`, default 5: shift-amount width; always equals log2(`XLEN`).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `flush` input, 1 bit: synchronous abort of the operation in flight.
- `in_valid` input, 1 bit: operands and opcode are valid.
- `in_ready` output, 1 bit: block can accept a new operation.
- `alu_ctr` input, 4 bits: operation code. Values are the shared `orders.vh` macros: `add`, `sub`, `sll`, `slt`, `sltu`, `xor`, `srl`, `sra`, `or`, `and`.
- `op_a` input, `XLEN` bits: operand A (rs1).
- `op_b` input, `XLEN` bits: operand B (rs2 or immediate).
- `out_valid` output, 1 bit: `result` and `zero` are valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `result` output, `XLEN` bits: registered result.
- `zero` output, 1 bit: `result == 0`, registered alongside `result`.
- `busy` output, 1 bit: high while in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE.
- Combinational ready: `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- Accept: when `in_valid & in_ready`, latch `alu_ctr`, `op_a`, and `cnt = op_b[SHW-1:0]`.
- Non-shift op, or any shift with `cnt==0`: compute at the accept edge, load `result`/`zero`, go to DONE.
- Shift with `cnt>0`: load the working register with `op_a` and go to SHIFT.
  - Each SHIFT cycle shifts by one bit and decrements `cnt`.
  - `sll` shifts left with zero fill.
  - `srl` shifts right with zero fill.
  - `sra` shifts right, replicating bit `XLEN-1`.
  - On the edge where `cnt` goes 1→0, go to DONE with `out_valid=1`.
- Arithmetic and width rules:
  - `add`/`sub` are modulo 2^XLEN; overflow is ignored.
  - `slt` is a signed compare and `sltu` is unsigned; both give 1 or 0, zero-extended.
  - Shift amount is `op_b[SHW-1:0]` only; upper bits of `op_b` are ignored.
  - Unknown `alu_ctr` code executes as `add`.
- DONE: hold `result`, `zero` and `out_valid` stable until `out_ready`.
  - On `out_ready` with no new accept: go to IDLE, `out_valid` falls.
  - On `out_ready` with a simultaneous accept: process the new op per the rules above. Back-to-back single-cycle ops sustain 1 op/cycle.
- `flush` (highest priority after reset):
  - Next state is IDLE, `out_valid` is 0, any SHIFT in progress is aborted.
  - `in_ready` is still computed combinationally, but an op offered in a flush cycle is discarded, not accepted.
  - `result` keeps its last value.
- Reset (`rst_n=0`, any time including mid-shift):
  - State IDLE, `out_valid=0`, `result=0`, `zero=0`, `cnt=0`, `busy=0`.
  - `in_ready` is 1 once reset is released.

## Timing
- Single-cycle ops: accept at edge N gives `out_valid=1` from edge N (visible in cycle N+1).
- Shifts: amount k≥1 gives `out_valid` at edge N+k; `busy=1` for k cycles; `in_ready=0` throughout SHIFT.
- Outputs are all registered. The only combinational input→output path is `out_ready` → `in_ready`.
- Once `out_valid` is asserted, `result` must not change until the handshake completes.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles, then release → `out_valid=0`, `result=0`, `zero=0`, `in_ready=1`.
- Back-to-back single-cycle ops with `out_ready=1`:
  - `add` 5,7 → 12.
  - `sub` 3,3 → 0 with `zero=1`.
  - `slt` 0xFFFFFFFF,1 → 1.
  - `sltu` 0xFFFFFFFF,1 → 0.
  - Results arrive on consecutive cycles with `in_ready` continuously high.
- Shifts:
  - `sra` 0x80000000 by 4 → 0xF8000000, valid exactly 4 cycles after accept, `busy` high for 4 cycles.
  - `srl` same operands → 0x08000000.
  - `sll` 1 by 31 → 0x80000000 after 31 cycles.
  - `sll` 0x12 by 0 → 0x12 in 1 cycle.
  - `sll` with `op_b=0x25` shifts by 5.
- Backpressure: `out_ready=0` for 5 cycles after `xor` 0xF0,0xFF → `result=0x0F` held stable, `in_ready=0`. Raise `out_ready` with a pending `or` → both handshakes complete on the same edge.
- Flush: assert `flush` during cycle 3 of a 10-bit shift → IDLE, `out_valid` never rises, `busy=0`. The next `and` 0xC,0xA → 0x8.
- Async reset during SHIFT with `out_valid` pending → state cleared immediately, no result emitted after reset is released.
